uart_chip_emu: RTL

UART_CHIP_EMU -- requirements
Module: uart_chip_emu

---
 rtl/uart_chip_emu_if.sv | 28 ++
 rtl/uart_chip_emu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_chip_emu_if.sv
// Host bus and serial pins of the UART chip emulator.
// master is the host/line side, slave is the UART.
interface uart_chip_emu_if;
  logic       rdn;
  logic       wrn;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       data_ready;
  logic       tbre;
  logic       tsre;
  logic       txd;
  logic       rxd;
  logic       overrun;
  logic       frame_err;

  modport master (
    output rdn, wrn, data_in, rxd,
    input  data_out, data_oe, data_ready,
    input  tbre, tsre, txd, overrun, frame_err
  );

  modport slave (
    input  rdn, wrn, data_in, rxd,
    output data_out, data_oe, data_ready,
    output tbre, tsre, txd, overrun, frame_err
  );
endinterface

// File: rtl/uart_chip_emu.sv
// Emulation of a strobe-driven UART chip: one-byte THR/RBR,
// 8N1 framing, mid-bit receive sampling.
module uart_chip_emu #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic            clk,
  input logic            rst,
  uart_chip_emu_if.slave bus
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } st_t;

  logic       rdn_q;
  logic       wrn_q;
  logic       rd_edge;
  logic       wr_edge;

  logic [7:0] thr;
  logic       thr_full;
  logic [7:0] rbr;
  logic [7:0] rbr_d;
  logic       rbr_ld;
  logic [7:0] hold;
  logic       ready;
  logic       ovr;
  logic       ferr;

  st_t        tx_st;
  st_t        tx_nx;
  logic [15:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic       tx_load;
  logic       tx_tick;

  logic       rx_s1;
  logic       rx_s2;
  logic       rx_prev;
  st_t        rx_st;
  st_t        rx_nx;
  logic [15:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic       rx_tick;
  logic       stop_ok;
  logic       stop_bad;

  assign rd_edge = !rdn_q && bus.rdn;
  assign wr_edge = !wrn_q && bus.wrn;

  assign bus.data_oe    = !bus.rdn;
  assign bus.data_out   = hold;
  assign bus.data_ready = ready;
  assign bus.overrun    = ovr;
  assign bus.frame_err  = ferr;
  assign bus.tbre       = !thr_full;
  assign bus.tsre       = (tx_st == IDLE) && !thr_full;
  assign bus.txd        = (tx_st == START) ? 1'b0 :
                          (tx_st == DATA)  ? tx_sh[0] : 1'b1;

  assign tx_tick = (tx_cnt == BIT_LAST);

  always_comb begin
    tx_nx   = tx_st;
    tx_load = 1'b0;
    unique case (tx_st)
      IDLE: begin
        if (thr_full) begin
          tx_nx   = START;
          tx_load = 1'b1;
        end
      end
      START: if (tx_tick) tx_nx = DATA;
      DATA: if (tx_tick && tx_bit == 3'd7) tx_nx = STOP;
      STOP: begin
        if (tx_tick) begin
          if (thr_full) begin
            tx_nx   = START;
            tx_load = 1'b1;
          end else begin
            tx_nx = IDLE;
          end
        end
      end
      default: tx_nx = IDLE;
    endcase
  end

  assign rx_tick = (rx_st == START) ? (rx_cnt == HALF_LAST)
                                    : (rx_cnt == BIT_LAST);

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      IDLE: if (rx_prev && !rx_s2) rx_nx = START;
      START: if (rx_tick) rx_nx = rx_s2 ? IDLE : DATA;
      DATA: if (rx_tick && rx_bit == 3'd7) rx_nx = STOP;
      STOP: if (rx_tick) rx_nx = IDLE;
      default: rx_nx = IDLE;
    endcase
  end

  assign stop_ok  = (rx_st == STOP) && rx_tick && rx_s2;
  assign stop_bad = (rx_st == STOP) && rx_tick && !rx_s2;
  assign rbr_ld   = stop_ok && !ready;
  assign rbr_d    = rbr_ld ? rx_sh : rbr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      thr      <= '0;
      thr_full <= 1'b0;
      tx_st    <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      rdn_q <= bus.rdn;
      wrn_q <= bus.wrn;
      tx_st <= tx_nx;
      if (tx_nx != tx_st || tx_tick || tx_st == IDLE)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 16'd1;
      if (tx_load) begin
        thr_full <= 1'b0;
        tx_sh    <= thr;
        tx_bit   <= '0;
      end else begin
        if (wr_edge && !thr_full) begin
          thr      <= bus.data_in;
          thr_full <= 1'b1;
        end
        if (tx_st == DATA && tx_tick) begin
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= tx_bit + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rbr     <= '0;
      hold    <= '0;
      ready   <= 1'b0;
      ovr     <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      rx_s1   <= bus.rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_nx;
      if (rx_nx != rx_st || rx_tick || rx_st == IDLE)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_st == IDLE) begin
        rx_bit <= '0;
      end else if (rx_st == DATA && rx_tick) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      // a load on the same edge as a read overrides the clear
      if (rd_edge) begin
        ready <= 1'b0;
        ovr   <= 1'b0;
      end
      if (rbr_ld) begin
        rbr   <= rx_sh;
        ready <= 1'b1;
      end else if (stop_ok) begin
        ovr <= 1'b1;
      end
      ferr <= stop_bad;
      // output byte is frozen while the host holds rdn low
      if (bus.rdn)
        hold <= rbr_d;
    end
  end

endmodule
